// File: rtl/c66x_power_pkg.sv
// c66x_power_pkg: sequencer state codes, supervisor FSM encoding
// and the small decode helpers shared by the power supervisor.
package c66x_power_pkg;

    localparam int FC_W = 4;

    localparam logic [FC_W-1:0] SEQ_OFF         = 4'h0;
    localparam logic [FC_W-1:0] SEQ_ON          = 4'h9;
    localparam logic [FC_W-1:0] SEQ_SHUTDOWN_LO = 4'hA;
    localparam logic [FC_W-1:0] SEQ_SHUTDOWN_HI = 4'hE;
    localparam logic [FC_W-1:0] SEQ_INVALID     = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTING,
        S_RUNNING,
        S_STOPPING,
        S_BACKOFF,
        S_LOCKOUT
    } sup_state_e;

    function automatic logic is_up(input logic [FC_W-1:0] c);
        return (c >= 4'h1) && (c <= 4'h8);
    endfunction

    function automatic logic is_bad(input logic [FC_W-1:0] c);
        return ((c >= SEQ_SHUTDOWN_LO) && (c <= SEQ_SHUTDOWN_HI))
            || (c == SEQ_INVALID);
    endfunction

endpackage

// File: rtl/power_tick_gen.sv
// power_tick_gen: free-running prescaler, one-cycle tick_o every
// TICK_DIV clocks (asserted while the counter sits at TICK_DIV-1).
module power_tick_gen #(
    parameter int TICK_DIV = 8192
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/c66x_power_supervisor.sv
// c66x_power_supervisor: drives the C66x sequencer enable, latches faults,
// retries with exponential backoff. WATCHDOG_EN adds a heartbeat watchdog.
module c66x_power_supervisor
    import c66x_power_pkg::*;
#(
    parameter int TICK_DIV      = 8192,
    parameter int STARTUP_LIMIT = 512,
    parameter int BACKOFF_BASE  = 32,
    parameter int MAX_RETRIES   = 3,
    parameter int WDOG_TICKS    = 256
) (
    input  logic            sysclk,
    input  logic            sysreset_INV,
    input  logic            board_enable,
    input  logic            clear_fault,
    input  logic [3:0]      seq_state,
    input  logic            heartbeat,
    output logic            seq_enable,
    output logic            fault_latched,
    output logic [FC_W-1:0] fault_code,
    output logic            fault_wdog,
    output logic [2:0]      retry_count,
    output logic            lockout,
    output logic            dsp_running
);

    localparam int BO_MAX = BACKOFF_BASE << (MAX_RETRIES - 1);
    localparam int T_MAX  = (STARTUP_LIMIT > BO_MAX) ? STARTUP_LIMIT : BO_MAX;
    localparam int TW     = $clog2(T_MAX + 1);

    sup_state_e state_q, state_d;

    logic [FC_W-1:0] s1_q, s2_q, st_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      retry_q, retry_d, retry_inc;
    logic            flt_q, flt_d, wdf_q, wdf_d;
    logic [FC_W-1:0] code_q, code_d, last_q, last_d;
    logic            att_q, att_d;
    logic            tick, wd_expire;
    logic            fault, fwd;
    logic [FC_W-1:0] fcode;
    logic [31:0]     bo_lim;

    power_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (sysclk),
        .rst_ni (sysreset_INV),
        .tick_o (tick)
    );

    // Slow-domain state bus: accept only values stable for two samples
    always_ff @(posedge sysclk or negedge sysreset_INV) begin
        if (!sysreset_INV) begin
            s1_q <= SEQ_OFF;
            s2_q <= SEQ_OFF;
            st_q <= SEQ_OFF;
        end else begin
            s1_q <= seq_state;
            s2_q <= s1_q;
            if (s1_q == s2_q) st_q <= s2_q;
        end
    end

`ifdef WATCHDOG_EN
    localparam int WW = $clog2(WDOG_TICKS + 1);

    logic [2:0]    hb_q;
    logic [WW-1:0] wd_q;
    logic          hb_edge;

    assign hb_edge = hb_q[1] & ~hb_q[2];

    always_ff @(posedge sysclk or negedge sysreset_INV) begin
        if (!sysreset_INV) begin
            hb_q <= '0;
            wd_q <= '0;
        end else begin
            hb_q <= {hb_q[1:0], heartbeat};
            if (state_q != S_RUNNING || hb_edge) wd_q <= '0;
            else if (tick && wd_q != '1)         wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_expire = (state_q == S_RUNNING) && (32'(wd_q) >= WDOG_TICKS);
`else
    logic unused_wd;
    assign unused_wd = heartbeat ^ (WDOG_TICKS != 0);
    assign wd_expire = 1'b0;
`endif

    assign retry_inc = retry_q + 3'd1;
    assign bo_lim    = 32'(BACKOFF_BASE) << (retry_q - 3'd1);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        flt_d   = flt_q;
        code_d  = code_q;
        wdf_d   = wdf_q;
        att_d   = att_q;
        last_d  = last_q;
        fault   = 1'b0;
        fcode   = st_q;
        fwd     = 1'b0;
        if (clear_fault) begin
            flt_d  = 1'b0;
            code_d = '0;
            wdf_d  = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                att_d  = 1'b0;
                last_d = '0;
                if (board_enable && st_q == SEQ_OFF) state_d = S_STARTING;
            end
            S_STARTING: begin
                if (is_up(st_q)) last_d = st_q;
                if (st_q == SEQ_ON) begin
                    state_d = S_RUNNING;
                    retry_d = '0;
                end else if (st_q == SEQ_INVALID) begin
                    fault = 1'b1;
                    fcode = SEQ_INVALID;
                end else if (is_bad(st_q)
                             || (st_q == SEQ_OFF && last_q != '0)) begin
                    fault = 1'b1;
                    fcode = last_q;
                end else if (32'(timer_q) >= STARTUP_LIMIT) begin
                    fault = 1'b1;
                end else if (!board_enable) begin
                    state_d = S_STOPPING;
                end
            end
            S_RUNNING: begin
                if (st_q != SEQ_ON) begin
                    fault = 1'b1;
                end else if (wd_expire) begin
                    fault = 1'b1;
                    fcode = SEQ_ON;
                    fwd   = 1'b1;
                end else if (!board_enable) begin
                    state_d = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (st_q == SEQ_OFF) begin
                    if (att_q) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc < 3'(MAX_RETRIES)) ? S_BACKOFF
                                                                : S_LOCKOUT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BACKOFF: begin
                if (!board_enable) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end else if (32'(timer_q) >= bo_lim) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (clear_fault) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new fault overrides both a clear and an enable drop
        if (fault) begin
            state_d = S_STOPPING;
            att_d   = 1'b1;
            flt_d   = 1'b1;
            code_d  = fcode;
            wdf_d   = fwd;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_INV) begin
        if (!sysreset_INV) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            retry_q <= '0;
            flt_q   <= 1'b0;
            code_q  <= '0;
            wdf_q   <= 1'b0;
            att_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)        timer_q <= '0;
            else if (tick && timer_q != '1) timer_q <= timer_q + 1'b1;
            retry_q <= retry_d;
            flt_q   <= flt_d;
            code_q  <= code_d;
            wdf_q   <= wdf_d;
            att_q   <= att_d;
            last_q  <= last_d;
        end
    end

    assign seq_enable    = (state_q == S_STARTING) || (state_q == S_RUNNING);
    assign dsp_running   = (state_q == S_RUNNING);
    assign lockout       = (state_q == S_LOCKOUT);
    assign fault_latched = flt_q;
    assign fault_code    = code_q;
    assign fault_wdog    = wdf_q;
    assign retry_count   = retry_q;

endmodule
